// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned PAR_EVEN             = 0;
    localparam int unsigned PAR_ODD              = 1;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses bit_tick on the last clk cycle of every serial bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned        CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops words from the TX FIFO read port and frames them
// as start / data (LSB first) / optional parity / stop bits on the tx line.
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = PAR_EVEN,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned            BIT_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_CNT_W-1:0]   LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]   LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    tx_state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parity_q, parity_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    tx_q, tx_d;
    logic                    fifo_rd_en_q, fifo_rd_en_d;
    logic                    busy_q, busy_d;
    logic                    tx_done_q, tx_done_d;
    logic                    bit_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == LOAD),
        .bit_tick(bit_tick)
    );

    // Next state plus next output values; outputs are registered from the next state
    // so each output flop holds exactly the decode of the current state register.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d   = fifo_data;
                parity_d  = (^fifo_data) ^ 1'(PARITY_ODD);
                bit_cnt_d = '0;
                state_d   = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase

        fifo_rd_en_d = (state_d == FETCH);
        busy_d       = (state_d != IDLE);
        tx_done_d    = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b1;
            fifo_rd_en_q <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = fifo_rd_en_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
UART transmitter that drains the TX FIFO through its read port and serialises each word onto the line.
- Framing: start bit, DATA_WIDTH data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Acts as the read-side consumer of the FIFO: it drives rd_en and samples empty and data_out.
- Sits between the TX FIFO and the pad.

Parameters:
DATA_WIDTH, 8, data bits per frame; must equal the FIFO word width in use.
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); minimum 2.
PARITY_EN, 1, 1 = insert parity bit after data.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0).
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
tx_en  input  1  level enable; new frames start only while high.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO data_out; registered in the FIFO, valid the cycle after rd_en.
fifo_rd_en  output  1  FIFO read strobe; high exactly one cycle per frame.
tx  output  1  serial line; idle high.
busy  output  1  high from FETCH through the final stop-bit cycle.
tx_done  output  1  one-cycle pulse after each completed frame.

Behaviour:
- Reset (async, immediate): state = IDLE, tx = 1, fifo_rd_en = 0, busy = 0, tx_done = 0, baud and bit counters = 0.
  - Reset mid-frame aborts the frame; tx goes high at once; the popped word is lost (accepted).
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx = 1. If tx_en && !fifo_empty, go to FETCH; otherwise stay.
- FETCH: exactly 1 cycle, fifo_rd_en = 1, busy = 1. Go to LOAD.
  - The FIFO updates data_out and empty on the edge that ends FETCH.
- LOAD: exactly 1 cycle, tx = 1.
  - Capture fifo_data into the shift register.
  - Compute parity = ^data XOR PARITY_ODD.
  - Clear baud and bit counters. Go to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift[0]. Each bit lasts CLKS_PER_BIT cycles, then shift right.
  - After bit DATA_WIDTH-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE with tx_done = 1 for that first IDLE cycle.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; bit ends when the count reaches CLKS_PER_BIT-1 and the counter wraps to 0.
- Bit counter: width $clog2(DATA_WIDTH)+1; wraps cleanly; no overflow beyond DATA_WIDTH.
- Frame length on the line = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: STOP → IDLE → FETCH → LOAD. The minimum inter-frame idle-high gap beyond the stop bits is 3 cycles; this is fixed.
- tx_en dropped mid-frame: the current frame completes normally; no further FETCH until tx_en rises again.
- fifo_empty is sampled only in IDLE. A FIFO going empty during a frame has no effect on that frame.
- fifo_rd_en is never asserted while fifo_empty = 1, so the FIFO underflow flag must never fire.
- fifo_data is ignored outside LOAD.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
  - Parity-mode constants PAR_EVEN = 0, PAR_ODD = 1.
  - Default CLKS_PER_BIT constant.
- One sub-module, uart_baud_gen: parameter CLKS_PER_BIT; inputs clk, rst, clear; output bit_tick (1-cycle pulse when the count reaches CLKS_PER_BIT-1).
- FSM and shift register stay in uart_tx_fifo_reader.

Test Plan:
All scenarios use CLKS_PER_BIT = 4, DATA_WIDTH = 8, STOP_BITS = 1, and the real FIFO connected unless stated.
1. Single frame. Push 0x55 (PARITY_EN = 1, even), tx_en = 1 → fifo_rd_en high 1 cycle; tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, parity 0, stop 1; 44 cycles total from START; tx_done pulses once.
2. Odd parity. PARITY_ODD = 1, push 0x07 → parity bit = 0 (three ones, odd parity already satisfied); push 0x03 → parity bit = 1.
3. Back-to-back. Push 0xA5, 0x3C, 0xFF → three frames in order; exactly 3 idle-high cycles after each stop bit; three fifo_rd_en pulses; FIFO underflow stays 0; busy falls after the third frame.
4. tx_en gating. Push 2 words, drop tx_en during frame 1's DATA state → frame 1 completes; word 2 stays in the FIFO (count = 1); raising tx_en starts frame 2 within 1 cycle.
5. Reset mid-frame. Assert rst during DATA bit 3 → tx = 1, busy = 0, fifo_rd_en = 0 asynchronously; after release, tx stays high with the FIFO empty; no tx_done pulse.
6. No parity, 2 stop bits. PARITY_EN = 0, STOP_BITS = 2, push 0x80 → frame is 0, seven 0s, 1, then stop high 8 cycles; 44 cycles total; tx_done at cycle 45.
